video_timing_fixup: RTL

Downstream stage of the line-doubler: consumes its doubled-rate sync and RGB stream, delays vsync by exactly one output line so it is line-aligned, and measures the incoming line length to lock onto the signal. It derives hblank/vblank/de from parameterised window offsets, forces RGB to zero outside the active window, and optionally applies the scanline darkening effect. Its output drives the video DAC/HDMI encoder.

---
 rtl/video_timing_fixup.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_fixup.sv
// video_timing_fixup: line-aligns vsync, measures line length for lock,
// derives hblank/vblank/de from window offsets and blanks RGB outside the
// active window. Optional scanline darkening is enabled by defining the
// macro SCANLINES_EN; without it the scanlines input is ignored.
module video_timing_fixup #(
  parameter int unsigned CNT_W        = 11,
  parameter int unsigned HS_TO_ACTIVE = 96,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned VS_TO_ACTIVE = 35,
  parameter int unsigned V_ACTIVE     = 480
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [1:0] scanlines,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic [4:0] r_in,
  input  logic [4:0] g_in,
  input  logic [4:0] b_in,
  output logic       hs_out,
  output logic       vs_out,
  output logic       hblank,
  output logic       vblank,
  output logic       de,
  output logic [4:0] r_out,
  output logic [4:0] g_out,
  output logic [4:0] b_out,
  output logic       locked
);

  localparam int unsigned CW1 = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0] H_BEG = CW1'(HS_TO_ACTIVE);
  localparam logic [CNT_W:0] H_END = CW1'(HS_TO_ACTIVE + H_ACTIVE);
  localparam logic [CNT_W:0] V_BEG = CW1'(VS_TO_ACTIVE);
  localparam logic [CNT_W:0] V_END = CW1'(VS_TO_ACTIVE + V_ACTIVE);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  state_t           r_state;
  logic             r_hs_prev;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic [CNT_W:0]   r_line_len;
  logic             r_vs_prev;
  logic             r_vs_line;
  logic             r_s1_hs;
  logic             r_s1_vs;
  logic             r_s1_hblank;
  logic             r_s1_vblank;
  logic [4:0]       r_s1_r;
  logic [4:0]       r_s1_g;
  logic [4:0]       r_s1_b;

  logic             w_ls;
  logic             w_ovf;
  logic             w_vs_lead;
  logic             w_vs_line_nxt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic [CNT_W-1:0] w_vcnt_nxt;
  logic [CNT_W:0]   w_len_nxt;
  logic [CNT_W:0]   w_len_diff;
  logic             w_hblank_nxt;
  logic             w_vblank_nxt;
  logic             w_de_nxt;
  logic [4:0]       w_r_nxt;
  logic [4:0]       w_g_nxt;
  logic [4:0]       w_b_nxt;

  // Line start, saturation overflow and next counter / sync values
  assign w_ls          = ce_pix & r_hs_prev & ~hs_in;
  assign w_ovf         = ce_pix & ~w_ls & (r_hcnt == CNT_MAX);
  assign w_vs_lead     = w_ls & r_vs_line & ~r_vs_prev;
  assign w_vs_line_nxt = w_ls ? r_vs_prev : r_vs_line;
  assign w_hcnt_nxt    = w_ls ? '0 :
                         ((r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + CNT_W'(1));
  assign w_vcnt_nxt    = !w_ls ? r_vcnt :
                         (w_vs_lead ? '0 :
                         ((r_vcnt == CNT_MAX) ? r_vcnt : r_vcnt + CNT_W'(1)));
  assign w_len_nxt     = CW1'(r_hcnt) + CW1'(1);
  assign w_len_diff    = (w_len_nxt >= r_line_len) ? (w_len_nxt - r_line_len)
                                                   : (r_line_len - w_len_nxt);
  assign w_hblank_nxt  = !((CW1'(w_hcnt_nxt) >= H_BEG) && (CW1'(w_hcnt_nxt) < H_END));
  assign w_vblank_nxt  = !((CW1'(w_vcnt_nxt) >= V_BEG) && (CW1'(w_vcnt_nxt) < V_END));

`ifdef SCANLINES_EN
  logic r_sl;
  logic r_s1_sl;
  logic w_sl_nxt;

  // Scanline parity: toggles per line, restarts at the vsync leading edge
  assign w_sl_nxt = !w_ls ? r_sl : (w_vs_lead ? 1'b0 : ~r_sl);

  function automatic logic [4:0] f_dim(input logic [4:0] x, input logic [1:0] m);
    case (m)
      2'b01:   f_dim = (x >> 1) + (x >> 2);
      2'b10:   f_dim = x >> 1;
      2'b11:   f_dim = x >> 2;
      default: f_dim = x;
    endcase
  endfunction

  // Scanline flag register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sl <= 1'b0;
    end else if (ce_pix) begin
      r_sl <= w_sl_nxt;
    end
  end
`else
  logic w_unused_scanlines;
  assign w_unused_scanlines = ^scanlines;
`endif

  // Counters, line length and line-aligned vsync
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hs_prev  <= 1'b0;
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_line_len <= '0;
      r_vs_prev  <= 1'b1;
      r_vs_line  <= 1'b1;
    end else if (ce_pix) begin
      r_hs_prev <= hs_in;
      r_hcnt    <= w_hcnt_nxt;
      r_vcnt    <= w_vcnt_nxt;
      if (w_ls) begin
        r_line_len <= w_len_nxt;
        r_vs_prev  <= vs_in;
        r_vs_line  <= r_vs_prev;
      end
    end
  end

  // Lock FSM: evaluated at line start, overflow forces a new search at once
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_SEARCH;
    end else if (w_ovf) begin
      r_state <= ST_SEARCH;
    end else if (w_ls) begin
      case (r_state)
        ST_SEARCH:  r_state <= ST_MEASURE;
        ST_MEASURE: if (w_len_nxt == r_line_len) r_state <= ST_LOCKED;
        ST_LOCKED:  if (w_len_diff > CW1'(2)) r_state <= ST_SEARCH;
        default:    r_state <= ST_SEARCH;
      endcase
    end
  end

  // Final enable and blanked / dimmed pixel data
  always_comb begin
    w_de_nxt = ~r_s1_hblank & ~r_s1_vblank & (r_state == ST_LOCKED);
    w_r_nxt  = '0;
    w_g_nxt  = '0;
    w_b_nxt  = '0;
    if (w_de_nxt) begin
      w_r_nxt = r_s1_r;
      w_g_nxt = r_s1_g;
      w_b_nxt = r_s1_b;
`ifdef SCANLINES_EN
      if (r_s1_sl && (scanlines != 2'b00)) begin
        w_r_nxt = f_dim(r_s1_r, scanlines);
        w_g_nxt = f_dim(r_s1_g, scanlines);
        w_b_nxt = f_dim(r_s1_b, scanlines);
      end
`endif
    end
  end

  // Two-stage output pipeline: stage 1 pairs pixel with its flags, stage 2 drives pins
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_s1_hs     <= 1'b1;
      r_s1_vs     <= 1'b1;
      r_s1_hblank <= 1'b1;
      r_s1_vblank <= 1'b1;
      r_s1_r      <= '0;
      r_s1_g      <= '0;
      r_s1_b      <= '0;
`ifdef SCANLINES_EN
      r_s1_sl     <= 1'b0;
`endif
      hs_out      <= 1'b1;
      vs_out      <= 1'b1;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      de          <= 1'b0;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
      locked      <= 1'b0;
    end else if (ce_pix) begin
      r_s1_hs     <= hs_in;
      r_s1_vs     <= w_vs_line_nxt;
      r_s1_hblank <= w_hblank_nxt;
      r_s1_vblank <= w_vblank_nxt;
      r_s1_r      <= r_in;
      r_s1_g      <= g_in;
      r_s1_b      <= b_in;
`ifdef SCANLINES_EN
      r_s1_sl     <= w_sl_nxt;
`endif
      hs_out      <= r_s1_hs;
      vs_out      <= r_s1_vs;
      hblank      <= r_s1_hblank;
      vblank      <= r_s1_vblank;
      de          <= w_de_nxt;
      r_out       <= w_r_nxt;
      g_out       <= w_g_nxt;
      b_out       <= w_b_nxt;
      locked      <= (r_state == ST_LOCKED);
    end
  end

endmodule
